// File: rtl/race_timer.sv
// ----------------------------------------------------------------------------
// race_timer
//
// Lap timer running from a 1 kHz clock. It keeps a running total
// (seconds + milliseconds) and a per-lap counter. It stores up to LAPS lap
// splits, and can optionally track the fastest lap.
//
// Optional feature macro:
//   RACE_TIMER_BEST_LAP_EN  - when defined, best-lap tracking (comparator and
//                             best registers) is built. When undefined, the
//                             best_* outputs are tied to 0.
//
// Ports:
//   clk1KHz     in   1 kHz clock. All logic uses the rising edge.
//   reset       in   Synchronous, active-low reset.
//   restart     in   Synchronous clear back to IDLE.
//   start       in   Begin or resume timing.
//   stop        in   Pause timing.
//   lap         in   Lap split event.
//   lap_rd_idx  in   Index of the stored lap to read.
//   seconds     out  Total elapsed seconds.
//   miliseconds out  Total elapsed milliseconds, 0..999.
//   state       out  FSM state (IDLE=0, RUNNING=1, PAUSED=2, FINISHED=3).
//   lap_count   out  Number of laps stored.
//   lap_rd_sec  out  Stored lap seconds at lap_rd_idx (0 if not stored).
//   lap_rd_ms   out  Stored lap milliseconds at lap_rd_idx (0 if not stored).
//   best_sec    out  Best lap seconds.
//   best_ms     out  Best lap milliseconds.
//   best_idx    out  Index of the best lap.
//   best_valid  out  A best lap exists.
//   finished    out  High in FINISHED.
//   overflow    out  Total or lap counter has saturated (sticky).
// ----------------------------------------------------------------------------
module race_timer #(
    parameter int SEC_W = 12,
    parameter int LAPS  = 4,
    parameter int LAP_W = 4
) (
    input  logic             clk1KHz,
    input  logic             reset,
    input  logic             restart,
    input  logic             start,
    input  logic             stop,
    input  logic             lap,
    input  logic [LAP_W-1:0] lap_rd_idx,
    output logic [SEC_W-1:0] seconds,
    output logic [9:0]       miliseconds,
    output logic [1:0]       state,
    output logic [LAP_W-1:0] lap_count,
    output logic [SEC_W-1:0] lap_rd_sec,
    output logic [9:0]       lap_rd_ms,
    output logic [SEC_W-1:0] best_sec,
    output logic [9:0]       best_ms,
    output logic [LAP_W-1:0] best_idx,
    output logic             best_valid,
    output logic             finished,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        PAUSED   = 2'd2,
        FINISHED = 2'd3
    } state_t;

    // Packed with seconds as the upper bits, so that a plain '<' compares
    // {sec, ms} in time order.
    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [9:0]       ms;
    } time_t;

    localparam logic [SEC_W-1:0] SEC_MAX = '1;
    localparam logic [9:0]       MS_MAX  = 10'd999;

    state_t           cur_state, nxt_state;
    time_t            tot_q, tot_nxt;
    time_t            lap_q, lap_nxt;
    time_t            laps_q [LAPS];
    logic [LAP_W-1:0] count_q;
    logic             ovf_q;
    logic             tick;
    logic             lap_wr;
    logic             last_lap;

    function automatic logic at_max(input time_t t);
        return (t.sec == SEC_MAX) && (t.ms == MS_MAX);
    endfunction

    // Adds 1 ms, with ms wrapping into seconds. The value holds once it
    // reaches the top.
    function automatic time_t sat_inc(input time_t t);
        time_t r;
        r = t;
        if (t.ms != MS_MAX) begin
            r.ms = t.ms + 10'd1;
        end else if (t.sec != SEC_MAX) begin
            r.sec = t.sec + 1'b1;
            r.ms  = 10'd0;
        end
        return r;
    endfunction

    assign tot_nxt  = sat_inc(tot_q);
    assign lap_nxt  = sat_inc(lap_q);
    assign last_lap = (count_q == LAP_W'(LAPS - 1));

    // Decodes the inputs by priority: restart > stop > lap > start.
    // 'tick' means the counters advance on this edge.
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        tick   = 1'b0;
        lap_wr = 1'b0;
        if (!restart && !stop) begin
            case (cur_state)
                IDLE, PAUSED: tick = start;
                RUNNING: begin
                    tick   = 1'b1;
                    lap_wr = lap;
                end
                default: ;
            endcase
        end
    end

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
    always_ff @(posedge clk1KHz) begin
        if (!reset) cur_state <= IDLE;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (restart) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:     if (tick) nxt_state = RUNNING;
                RUNNING: begin
                    if (stop)                    nxt_state = PAUSED;
                    else if (lap_wr && last_lap) nxt_state = FINISHED;
                end
                PAUSED:   if (tick) nxt_state = RUNNING;
                default:  nxt_state = cur_state;
            endcase
        end
    end

    // ---------------- counters and lap store ----------------
    // NOTE: the lap store is cleared on reset and restart, because stored laps must read 0 afterwards; it is a small register file, not a RAM.
    always_ff @(posedge clk1KHz) begin
        if (!reset || restart) begin
            tot_q   <= '0;
            lap_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < LAPS; i++) laps_q[i] <= '0;
        end else if (tick) begin
            tot_q <= tot_nxt;
            if (at_max(tot_q) || at_max(lap_q)) ovf_q <= 1'b1;
            if (lap_wr) begin
                // Store the split including this cycle's millisecond, so
                // that the laps add up to the total.
                for (int i = 0; i < LAPS; i++) begin
                    if (count_q == LAP_W'(i)) laps_q[i] <= lap_nxt;
                end
                count_q <= count_q + LAP_W'(1);
                lap_q   <= '0;
            end else begin
                lap_q <= lap_nxt;
            end
        end
    end

    // Combinational read port. Entries at or above lap_count read 0.
    always_comb begin
        lap_rd_sec = '0;
        lap_rd_ms  = '0;
        for (int i = 0; i < LAPS; i++) begin
            if ((lap_rd_idx == LAP_W'(i)) && (LAP_W'(i) < count_q)) begin
                lap_rd_sec = laps_q[i].sec;
                lap_rd_ms  = laps_q[i].ms;
            end
        end
    end

    // ---------------- best lap ----------------
`ifdef RACE_TIMER_BEST_LAP_EN
    time_t            best_q;
    logic [LAP_W-1:0] best_idx_q;
    logic             best_valid_q;

    // The compare is strict, so on a tie the earlier lap is kept.
    always_ff @(posedge clk1KHz) begin
        if (!reset || restart) begin
            best_q       <= '0;
            best_idx_q   <= '0;
            best_valid_q <= 1'b0;
        end else if (lap_wr && (!best_valid_q || (lap_nxt < best_q))) begin
            best_q       <= lap_nxt;
            best_idx_q   <= count_q;
            best_valid_q <= 1'b1;
        end
    end

    assign best_sec   = best_q.sec;
    assign best_ms    = best_q.ms;
    assign best_idx   = best_idx_q;
    assign best_valid = best_valid_q;
`else
    assign best_sec   = '0;
    assign best_ms    = '0;
    assign best_idx   = '0;
    assign best_valid = 1'b0;
`endif

    assign seconds     = tot_q.sec;
    assign miliseconds = tot_q.ms;
    assign state       = cur_state;
    assign lap_count   = count_q;
    assign finished    = (cur_state == FINISHED);
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_race_timer.sv
// ----------------------------------------------------------------------------
// tb_race_timer
//
// Directed testbench for race_timer. The main instance uses the default
// parameters. A second instance with SEC_W=2 exercises saturation.
// Inputs are driven 1 time unit after a rising edge, and outputs are sampled
// at that same point.
// ----------------------------------------------------------------------------
module tb_race_timer;

    logic        clk1KHz = 1'b0;
    logic        reset, restart, start, stop, lap;
    logic [3:0]  lap_rd_idx;
    logic [11:0] seconds, lap_rd_sec, best_sec;
    logic [9:0]  miliseconds, lap_rd_ms, best_ms;
    logic [1:0]  state;
    logic [3:0]  lap_count, best_idx;
    logic        best_valid, finished, overflow;

    // Saturation instance (SEC_W = 2)
    logic        s_restart, s_start, s_stop, s_lap;
    logic [3:0]  s_lap_rd_idx;
    logic [1:0]  s_seconds, s_lap_rd_sec, s_best_sec;
    logic [9:0]  s_miliseconds, s_lap_rd_ms, s_best_ms;
    logic [1:0]  s_state;
    logic [3:0]  s_lap_count, s_best_idx;
    logic        s_best_valid, s_finished, s_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk1KHz = ~clk1KHz;

    race_timer dut (
        .clk1KHz(clk1KHz), .reset(reset), .restart(restart), .start(start),
        .stop(stop), .lap(lap), .lap_rd_idx(lap_rd_idx),
        .seconds(seconds), .miliseconds(miliseconds), .state(state),
        .lap_count(lap_count), .lap_rd_sec(lap_rd_sec), .lap_rd_ms(lap_rd_ms),
        .best_sec(best_sec), .best_ms(best_ms), .best_idx(best_idx),
        .best_valid(best_valid), .finished(finished), .overflow(overflow)
    );

    race_timer #(.SEC_W(2), .LAPS(4), .LAP_W(4)) dut_sat (
        .clk1KHz(clk1KHz), .reset(reset), .restart(s_restart), .start(s_start),
        .stop(s_stop), .lap(s_lap), .lap_rd_idx(s_lap_rd_idx),
        .seconds(s_seconds), .miliseconds(s_miliseconds), .state(s_state),
        .lap_count(s_lap_count), .lap_rd_sec(s_lap_rd_sec), .lap_rd_ms(s_lap_rd_ms),
        .best_sec(s_best_sec), .best_ms(s_best_ms), .best_idx(s_best_idx),
        .best_valid(s_best_valid), .finished(s_finished), .overflow(s_overflow)
    );

    task automatic cycle(input int n);
        repeat (n) @(posedge clk1KHz);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1; cycle(1); restart = 1'b0;
    endtask

    // One start edge; the first millisecond counts on this edge.
    task automatic do_start();
        start = 1'b1; cycle(1); start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; cycle(2);
        checks++; if (state !== 2'd0)       begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (seconds !== 12'd0)    begin errors++; $display("FAIL reset_sec got %0d exp 0", seconds); end
        checks++; if (miliseconds !== 10'd0) begin errors++; $display("FAIL reset_ms got %0d exp 0", miliseconds); end
        checks++; if (lap_count !== 4'd0)   begin errors++; $display("FAIL reset_lap_count got %0d exp 0", lap_count); end
        checks++; if ({finished, overflow, best_valid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {finished, overflow, best_valid}); end
        reset = 1'b1; cycle(1);
        checks++; if (state !== 2'd0)       begin errors++; $display("FAIL idle_hold got %0d exp 0", state); end
    endtask

    task automatic test_run();
        do_start();
        checks++; if ({seconds, miliseconds} !== {12'd0, 10'd1}) begin errors++; $display("FAIL first_tick got %0d.%0d exp 0.1", seconds, miliseconds); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_state got %0d exp 1", state); end
        cycle(1499);
        checks++; if ({seconds, miliseconds} !== {12'd1, 10'd500}) begin errors++; $display("FAIL run_1500 got %0d.%0d exp 1.500", seconds, miliseconds); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_1500_state got %0d exp 1", state); end
    endtask

    task automatic test_pause();
        logic changed;
        do_restart();
        checks++; if ({state, seconds, miliseconds} !== 24'd0) begin errors++; $display("FAIL restart got st %0d %0d.%0d exp 0 0.0", state, seconds, miliseconds); end
        do_start(); cycle(299);
        checks++; if (miliseconds !== 10'd300) begin errors++; $display("FAIL pause_pre got %0d exp 300", miliseconds); end
        stop = 1'b1; cycle(1); stop = 1'b0;
        checks++; if (state !== 2'd2 || miliseconds !== 10'd300) begin errors++; $display("FAIL stop_edge got st %0d ms %0d exp st 2 ms 300", state, miliseconds); end
        changed = 1'b0;
        for (int i = 0; i < 199; i++) begin
            cycle(1);
            if (state !== 2'd2 || miliseconds !== 10'd300 || seconds !== 12'd0) changed = 1'b1;
        end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL paused_frozen got changed=%b exp 0", changed); end
        do_start(); cycle(99);
        checks++; if ({seconds, miliseconds} !== {12'd0, 10'd400}) begin errors++; $display("FAIL resume got %0d.%0d exp 0.400", seconds, miliseconds); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state got %0d exp 1", state); end
    endtask

    task automatic test_laps();
        int lap_at [4];
        int exp_ms [4];
        int e;
        lap_at = '{250, 450, 750, 800};
        exp_ms = '{250, 200, 300, 50};
        do_restart();
        do_start();
        e = 1;
        for (int k = 0; k < 4; k++) begin
            cycle(lap_at[k] - 1 - e);
            lap = 1'b1; cycle(1); lap = 1'b0;
            e = lap_at[k];
            if (k == 0) begin
                checks++; if (lap_count !== 4'd1) begin errors++; $display("FAIL lap1_count got %0d exp 1", lap_count); end
                lap_rd_idx = 4'd1; #1;
                checks++; if ({lap_rd_sec, lap_rd_ms} !== 22'd0) begin errors++; $display("FAIL rd_unstored got %0d.%0d exp 0.0", lap_rd_sec, lap_rd_ms); end
                lap_rd_idx = 4'd0; #1;
                checks++; if ({lap_rd_sec, lap_rd_ms} !== {12'd0, 10'd250}) begin errors++; $display("FAIL rd_lap0_early got %0d.%0d exp 0.250", lap_rd_sec, lap_rd_ms); end
`ifdef RACE_TIMER_BEST_LAP_EN
                checks++; if ({best_valid, best_idx, best_ms} !== {1'b1, 4'd0, 10'd250}) begin errors++; $display("FAIL best_first got v%0d i%0d ms%0d exp v1 i0 ms250", best_valid, best_idx, best_ms); end
`endif
            end
        end
        checks++; if (state !== 2'd3 || finished !== 1'b1) begin errors++; $display("FAIL finish_state got st %0d fin %0d exp 3 1", state, finished); end
        checks++; if (lap_count !== 4'd4) begin errors++; $display("FAIL finish_count got %0d exp 4", lap_count); end
        checks++; if ({seconds, miliseconds} !== {12'd0, 10'd800}) begin errors++; $display("FAIL finish_total got %0d.%0d exp 0.800", seconds, miliseconds); end
        for (int k = 0; k < 4; k++) begin
            lap_rd_idx = 4'(k); #1;
            checks++; if (lap_rd_sec !== 12'd0 || lap_rd_ms !== 10'(exp_ms[k])) begin errors++; $display("FAIL lap_rd_%0d got %0d.%0d exp 0.%0d", k, lap_rd_sec, lap_rd_ms, exp_ms[k]); end
        end
        lap_rd_idx = 4'd4; #1;
        checks++; if ({lap_rd_sec, lap_rd_ms} !== 22'd0) begin errors++; $display("FAIL rd_idx4 got %0d.%0d exp 0.0", lap_rd_sec, lap_rd_ms); end
        lap_rd_idx = 4'd0;
`ifdef RACE_TIMER_BEST_LAP_EN
        checks++; if ({best_valid, best_idx, best_sec, best_ms} !== {1'b1, 4'd3, 12'd0, 10'd50}) begin errors++; $display("FAIL best_lap got v%0d i%0d %0d.%0d exp v1 i3 0.050", best_valid, best_idx, best_sec, best_ms); end
`else
        checks++; if ({best_valid, best_idx, best_sec, best_ms} !== 27'd0) begin errors++; $display("FAIL best_tied got v%0d i%0d %0d.%0d exp all 0", best_valid, best_idx, best_sec, best_ms); end
`endif
        // FINISHED ignores start and lap, and holds the total.
        do_start(); lap = 1'b1; cycle(1); lap = 1'b0; cycle(48);
        checks++; if (state !== 2'd3 || lap_count !== 4'd4) begin errors++; $display("FAIL finish_hold got st %0d cnt %0d exp 3 4", state, lap_count); end
        checks++; if ({seconds, miliseconds} !== {12'd0, 10'd800}) begin errors++; $display("FAIL finish_frozen got %0d.%0d exp 0.800", seconds, miliseconds); end
    endtask

    task automatic test_stop_lap();
        do_restart();
        do_start(); cycle(9);
        checks++; if (miliseconds !== 10'd10) begin errors++; $display("FAIL sl_pre got %0d exp 10", miliseconds); end
        stop = 1'b1; lap = 1'b1; cycle(1); stop = 1'b0; lap = 1'b0;
        checks++; if (state !== 2'd2 || lap_count !== 4'd0 || miliseconds !== 10'd10) begin errors++; $display("FAIL stop_lap got st %0d cnt %0d ms %0d exp 2 0 10", state, lap_count, miliseconds); end
        lap = 1'b1; cycle(1); lap = 1'b0;
        checks++; if (state !== 2'd2 || lap_count !== 4'd0) begin errors++; $display("FAIL lap_paused got st %0d cnt %0d exp 2 0", state, lap_count); end
    endtask

    task automatic test_overflow();
        s_start = 1'b1; cycle(1); s_start = 1'b0;
        cycle(3997);
        checks++; if ({s_seconds, s_miliseconds, s_overflow} !== {2'd3, 10'd998, 1'b0}) begin errors++; $display("FAIL sat_pre got %0d.%0d ovf %0d exp 3.998 ovf 0", s_seconds, s_miliseconds, s_overflow); end
        cycle(1002);
        checks++; if ({s_seconds, s_miliseconds} !== {2'd3, 10'd999}) begin errors++; $display("FAIL sat_value got %0d.%0d exp 3.999", s_seconds, s_miliseconds); end
        checks++; if (s_overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got %0d exp 1", s_overflow); end
    endtask

    task automatic test_midrun_reset();
        do_restart();
        do_start(); cycle(99);
        lap = 1'b1; cycle(1); lap = 1'b0; cycle(50);
        checks++; if (lap_count !== 4'd1 || miliseconds !== 10'd151) begin errors++; $display("FAIL mr_pre got cnt %0d ms %0d exp 1 151", lap_count, miliseconds); end
        reset = 1'b0; restart = 1'b1; start = 1'b1; lap = 1'b1; lap_rd_idx = 4'd0;
        cycle(1);
        checks++; if ({state, seconds, miliseconds, lap_count} !== 28'd0) begin errors++; $display("FAIL mr_core got st %0d %0d.%0d cnt %0d exp all 0", state, seconds, miliseconds, lap_count); end
        checks++; if ({lap_rd_sec, lap_rd_ms, best_sec, best_ms, best_idx} !== 48'd0) begin errors++; $display("FAIL mr_laps got rd %0d.%0d best %0d.%0d i%0d exp all 0", lap_rd_sec, lap_rd_ms, best_sec, best_ms, best_idx); end
        checks++; if ({best_valid, finished, overflow, s_overflow} !== 4'd0) begin errors++; $display("FAIL mr_flags got %b exp 0000", {best_valid, finished, overflow, s_overflow}); end
        restart = 1'b0; start = 1'b0; lap = 1'b0; reset = 1'b1;
        cycle(1);
        checks++; if (state !== 2'd0 || miliseconds !== 10'd0) begin errors++; $display("FAIL mr_release got st %0d ms %0d exp 0 0", state, miliseconds); end
    endtask

    initial begin
        reset = 1'b0; restart = 1'b0; start = 1'b0; stop = 1'b0; lap = 1'b0; lap_rd_idx = '0;
        s_restart = 1'b0; s_start = 1'b0; s_stop = 1'b0; s_lap = 1'b0; s_lap_rd_idx = '0;
        test_reset();
        test_run();
        test_pause();
        test_laps();
        test_stop_lap();
        test_overflow();
        test_midrun_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
